// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: opcodes, FSM states,
// the divide-by-zero quotient value and a magnitude helper.
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        WR   = 3'd4
    } hilo_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative radix-2 restoring divider on operand magnitudes, one quotient bit per
// cycle, with the sign fix-up applied to the final quotient/remainder.
module hilo_div_core
    import hilo_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        last_o,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CNT_W     = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam int PRE_SHIFT = 32 - DIV_ITERS;

    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      sh_q;
    logic [31:0]      div_q;
    logic [31:0]      a_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div0_q;

    logic [32:0] part;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] rem_d;
    logic [31:0] sh_d;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign mag_a = mag32(a_i, signed_i);
    assign mag_b = mag32(b_i, signed_i);

    // sh_q holds the remaining dividend bits at the top and collects quotient bits at the bottom.
    always_comb begin
        part  = {rem_q, sh_q[31]};
        diff  = part - {1'b0, div_q};
        qbit  = (part >= {1'b0, div_q});
        rem_d = qbit ? diff[31:0] : part[31:0];
        sh_d  = {sh_q[30:0], qbit};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            sh_q      <= '0;
            div_q     <= '0;
            a_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                busy_q <= 1'b0;
            end else if (start_i) begin
                busy_q    <= 1'b1;
                cnt_q     <= CNT_W'(DIV_ITERS - 1);
                rem_q     <= '0;
                sh_q      <= mag_a << PRE_SHIFT;
                div_q     <= mag_b;
                a_q       <= a_i;
                neg_quo_q <= signed_i & (a_i[31] ^ b_i[31]);
                neg_rem_q <= signed_i & a_i[31];
                div0_q    <= (b_i == 32'd0);
            end else if (busy_q) begin
                rem_q <= rem_d;
                sh_q  <= sh_d;
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign last_o = busy_q && (cnt_q == '0);
    assign done_o = done_q;
    assign quot_o = div0_q ? DIV0_LO : (neg_quo_q ? (~sh_q + 32'd1) : sh_q);
    assign rem_o  = div0_q ? a_q : (neg_rem_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: multiply pipeline, divider handshake and HI/LO write mux.
// Define HILO_MADD_EN to enable the MADD/MSUB accumulate operations.
//
// state | meaning
// IDLE  | waiting for Start
// MUL   | multiply pipeline delay (down-counter to terminal count)
// DIV   | divider core iterating
// FIX   | capture sign-corrected quotient/remainder
// WR    | HI_Ld/LO_Ld and Done asserted for one cycle
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] HI_cur,
    input  logic [31:0] LO_cur,
    input  logic        Abort,
    input  logic        MfRead,
    output logic        HI_Ld,
    output logic        LO_Ld,
    output logic [31:0] HI_in,
    output logic [31:0] LO_in,
    output logic        Busy,
    output logic        Stall,
    output logic        Done
);

    hilo_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] mul_q, mul_d;
    logic        hi_ld_q, hi_ld_d;
    logic        lo_ld_q, lo_ld_d;
    logic [31:0] hi_in_q, hi_in_d;
    logic [31:0] lo_in_q, lo_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef HILO_MADD_EN
    logic [63:0] acc_q, acc_d;
    logic        sub_q, sub_d;
    logic        madd_q, madd_d;
`else
    logic        unused_cur;
    assign unused_cur = ^{HI_cur, LO_cur};
`endif

    logic        [63:0] prod_u;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_now;
    logic        [63:0] mul_result;

    logic        div_start;
    logic        div_last;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    // Operands extended to 64 bits so the low 64 product bits equal the true product.
    assign prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u   = {32'd0, A} * {32'd0, B};
    assign prod_now = (Op == OP_MULTU) ? prod_u : prod_s;

`ifdef HILO_MADD_EN
    assign mul_result = madd_q ? (sub_q ? (acc_q - mul_q) : (acc_q + mul_q)) : mul_q;
`else
    assign mul_result = mul_q;
`endif

    assign div_start = (state_q == IDLE) && Start && !Abort
                       && ((Op == OP_DIV) || (Op == OP_DIVU));

    hilo_div_core #(
        .DIV_ITERS(DIV_ITERS)
    ) u_div (
        .Clk      (Clk),
        .Rst      (Rst),
        .start_i  (div_start),
        .abort_i  (Abort),
        .signed_i (Op == OP_DIV),
        .a_i      (A),
        .b_i      (B),
        .last_o   (div_last),
        .done_o   (div_done),
        .quot_o   (div_quot),
        .rem_o    (div_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        hi_ld_d = 1'b0;
        lo_ld_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        hi_in_d = hi_in_q;
        lo_in_d = lo_in_q;
`ifdef HILO_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
        madd_d  = madd_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Start && !Abort) begin
                    case (Op)
                        OP_MTHI: begin
                            state_d = WR;
                            hi_ld_d = 1'b1;
                            hi_in_d = A;
                            done_d  = 1'b1;
                        end
                        OP_MTLO: begin
                            state_d = WR;
                            lo_ld_d = 1'b1;
                            lo_in_d = A;
                            done_d  = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            busy_d = 1'b1;
`ifdef HILO_MADD_EN
                            madd_d = 1'b0;
`endif
                            if (MUL_LAT == 1) begin
                                state_d = WR;
                                hi_ld_d = 1'b1;
                                lo_ld_d = 1'b1;
                                done_d  = 1'b1;
                                hi_in_d = prod_now[63:32];
                                lo_in_d = prod_now[31:0];
                            end else begin
                                state_d = MUL;
                                mul_d   = prod_now;
                                cnt_d   = 2'(MUL_LAT - 2);
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            busy_d  = 1'b1;
                        end
`ifdef HILO_MADD_EN
                        // One extra MUL cycle covers the 64-bit accumulate.
                        OP_MADD, OP_MSUB: begin
                            state_d = MUL;
                            busy_d  = 1'b1;
                            mul_d   = prod_now;
                            cnt_d   = 2'(MUL_LAT - 1);
                            acc_d   = {HI_cur, LO_cur};
                            sub_d   = (Op == OP_MSUB);
                            madd_d  = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == 2'd0) begin
                    state_d = WR;
                    hi_ld_d = 1'b1;
                    lo_ld_d = 1'b1;
                    done_d  = 1'b1;
                    hi_in_d = mul_result[63:32];
                    lo_in_d = mul_result[31:0];
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_done) begin
                    state_d = WR;
                    hi_ld_d = 1'b1;
                    lo_ld_d = 1'b1;
                    done_d  = 1'b1;
                    hi_in_d = div_rem;
                    lo_in_d = div_quot;
                end
            end
            WR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A flush drops whatever is in flight, including a write scheduled for the next edge.
        if (Abort && (state_q != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            hi_ld_d = 1'b0;
            lo_ld_d = 1'b0;
            done_d  = 1'b0;
            hi_in_d = hi_in_q;
            lo_in_d = lo_in_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_q   <= '0;
            hi_ld_q <= 1'b0;
            lo_ld_q <= 1'b0;
            hi_in_q <= '0;
            lo_in_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef HILO_MADD_EN
            acc_q   <= '0;
            sub_q   <= 1'b0;
            madd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            hi_ld_q <= hi_ld_d;
            lo_ld_q <= lo_ld_d;
            hi_in_q <= hi_in_d;
            lo_in_q <= lo_in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef HILO_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            madd_q  <= madd_d;
`endif
        end
    end

    assign HI_Ld = hi_ld_q;
    assign LO_Ld = lo_ld_q;
    assign HI_in = hi_in_q;
    assign LO_in = lo_in_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Stall = MfRead & (busy_q | Start);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed literal cases plus randomized
// operations checked every cycle against a schedule/arithmetic reference model.
module tb_hilo_muldiv_ctrl;

    localparam int MUL_LAT   = 2;
    localparam int DIV_ITERS = 32;
    localparam int DIV_LAT   = DIV_ITERS + 2;
`ifdef HILO_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2, T_DIVU = 3'd3;
    localparam logic [2:0] T_MTHI = 3'd4, T_MTLO = 3'd5, T_MADD = 3'd6, T_MSUB = 3'd7;

    logic        Clk = 1'b0;
    logic        Rst, Start, Abort, MfRead;
    logic [2:0]  Op;
    logic [31:0] A, B, HI_cur, LO_cur;
    logic        HI_Ld, LO_Ld, Busy, Stall, Done;
    logic [31:0] HI_in, LO_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference schedule: the cycle of the write and the span of Busy for the op in flight.
    int          wr_cyc  = -1;
    int          busy_lo = -1;
    int          busy_hi = -1;
    bit          exp_hld, exp_lld;
    logic [31:0] exp_hi, exp_lo;
    logic        cmp_wr, cmp_busy;

    logic [2:0]  rop;
    logic [31:0] ra, rb;

    hilo_muldiv_ctrl #(
        .MUL_LAT   (MUL_LAT),
        .DIV_ITERS (DIV_ITERS)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .HI_cur (HI_cur),
        .LO_cur (LO_cur),
        .Abort  (Abort),
        .MfRead (MfRead),
        .HI_Ld  (HI_Ld),
        .LO_Ld  (LO_Ld),
        .HI_in  (HI_in),
        .LO_in  (LO_in),
        .Busy   (Busy),
        .Stall  (Stall),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        HI_cur = $urandom;
        LO_cur = $urandom;
        MfRead = 1'($urandom_range(0, 1));
    endtask

    // Arithmetic reference for an op started in the current cycle.
    task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hc, input logic [31:0] lc);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        int          k;
        k  = cyc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            T_MULT, T_MULTU: begin
                if (op == T_MULT) p = 64'(sa * sb);
                else              p = {32'd0, a} * {32'd0, b};
                wr_cyc = k + MUL_LAT; busy_lo = k + 1; busy_hi = wr_cyc;
                exp_hld = 1; exp_lld = 1; exp_hi = p[63:32]; exp_lo = p[31:0];
            end
            T_DIV, T_DIVU: begin
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF; exp_hi = a;
                end else begin
                    if (op == T_DIV) begin
                        q = sa / sb; r = sa % sb;
                        qv = 64'(q); rv = 64'(r);
                    end else begin
                        qv = {32'd0, a} / {32'd0, b};
                        rv = {32'd0, a} % {32'd0, b};
                    end
                    exp_lo = qv[31:0]; exp_hi = rv[31:0];
                end
                wr_cyc = k + DIV_LAT; busy_lo = k + 1; busy_hi = wr_cyc;
                exp_hld = 1; exp_lld = 1;
            end
            T_MTHI, T_MTLO: begin
                wr_cyc = k + 1; busy_lo = -1; busy_hi = -1;
                exp_hld = (op == T_MTHI); exp_lld = (op == T_MTLO);
                exp_hi = a; exp_lo = a;
            end
            default: begin
                if (MADD_ON) begin
                    if (op == T_MADD) p = {hc, lc} + 64'(sa * sb);
                    else              p = {hc, lc} - 64'(sa * sb);
                    wr_cyc = k + MUL_LAT + 1; busy_lo = k + 1; busy_hi = wr_cyc;
                    exp_hld = 1; exp_lld = 1; exp_hi = p[63:32]; exp_lo = p[31:0];
                end
            end
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit ab);
        checks++;
        if (!(cyc > wr_cyc && cyc > busy_hi)) begin
            errors++;
            $display("FAIL start_while_busy: start at cycle %0d, busy until %0d", cyc, busy_hi);
        end
        Op = op; A = a; B = b; Start = 1'b1; Abort = ab;
        if (!ab) model_issue(op, a, b, HI_cur, LO_cur);
        tick();
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic do_abort();
        Abort = 1'b1;
        if (wr_cyc > cyc)  wr_cyc  = -1;
        if (busy_hi > cyc) busy_hi = cyc;
        tick();
        Abort = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cyc > wr_cyc && cyc > busy_hi)) begin
            tick();
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL wait_idle: timeout at cycle %0d", cyc);
                break;
            end
        end
    endtask

    // Hand-computed expectations, independent of the model.
    task automatic directed(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hc, input logic [31:0] lc,
                            input bit wr, input int lat, input bit hld, input bit lld,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int k, seen;
        wait_idle();
        HI_cur = hc; LO_cur = lc;
        k = cyc;
        issue(op, a, b, 1'b0);
        seen = -1;
        for (int i = 0; i < DIV_LAT + 6 && seen < 0; i++) begin
            if (Done) seen = cyc;
            else tick();
        end
        if (wr) begin
            chk({nm, "_lat"}, 64'(seen - k), 64'(lat));
            chk({nm, "_hild"}, HI_Ld, hld);
            chk({nm, "_lold"}, LO_Ld, lld);
            if (hld) chk({nm, "_hi"}, HI_in, ehi);
            if (lld) chk({nm, "_lo"}, LO_in, elo);
        end else begin
            chk({nm, "_nowrite"}, 64'(seen), 64'(-1));
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            chk("rst_hi_ld", HI_Ld, 0);
            chk("rst_lo_ld", LO_Ld, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            chk("rst_hi_in", HI_in, 0);
            chk("rst_lo_in", LO_in, 0);
        end else begin
            cmp_wr   = (cyc == wr_cyc);
            cmp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", Busy, cmp_busy);
            chk("done", Done, cmp_wr);
            chk("hi_ld", HI_Ld, cmp_wr && exp_hld);
            chk("lo_ld", LO_Ld, cmp_wr && exp_lld);
            if (cmp_wr && exp_hld) chk("hi_in", HI_in, exp_hi);
            if (cmp_wr && exp_lld) chk("lo_in", LO_in, exp_lo);
            chk("stall", Stall, MfRead & (cmp_busy | Start));
        end
    end

    initial begin
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; MfRead = 1'b0;
        Op = 3'd0; A = '0; B = '0; HI_cur = '0; LO_cur = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        tick();

        directed("mult",  T_MULT,  32'hFFFF_FFFE, 32'd3, 0, 0, 1, 2, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        directed("multu", T_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0, 1, 2, 1, 1, 32'h0000_0002, 32'hFFFF_FFFA);
        directed("div",   T_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 1, 34, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("divu",  T_DIVU,  32'd100, 32'd7, 0, 0, 1, 34, 1, 1, 32'd2, 32'd14);
        directed("div0",  T_DIVU,  32'h1234_5678, 32'd0, 0, 0, 1, 34, 1, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        directed("divov", T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 34, 1, 1, 32'd0, 32'h8000_0000);
        directed("mtlo",  T_MTLO,  32'hCAFE_F00D, 32'd0, 0, 0, 1, 1, 0, 1, 32'd0, 32'hCAFE_F00D);
        directed("mthi",  T_MTHI,  32'h1357_9BDF, 32'd0, 0, 0, 1, 1, 1, 0, 32'h1357_9BDF, 32'd0);
        if (MADD_ON)
            directed("madd", T_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1, 3, 1, 1, 32'd1, 32'd0);
        else
            directed("madd", T_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0, 32'd0);

        // DIV aborted ten cycles in, with an MFHI waiting.
        wait_idle();
        issue(T_DIV, 32'd1000, 32'd3, 1'b0);
        MfRead = 1'b1;
        #1 chk("stall_busy", Stall, 1);
        while (cyc < wr_cyc - DIV_LAT + 10) tick();
        do_abort();
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        repeat (3) tick();

        // Reset mid-divide clears everything at once.
        wait_idle();
        issue(T_DIVU, 32'hDEAD_BEEF, 32'd5, 1'b0);
        repeat (5) tick();
        Rst = 1'b1;
        wr_cyc = -1; busy_lo = -1; busy_hi = -1;
        #1;
        chk("rstmid_busy", Busy, 0);
        chk("rstmid_hild", HI_Ld, 0);
        chk("rstmid_hi_in", HI_in, 0);
        tick();
        Rst = 1'b0;
        tick();

        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                issue(rop, ra, rb, 1'b1);
            end else begin
                issue(rop, ra, rb, 1'b0);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(0, 6)) tick();
                    do_abort();
                end
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencer for the HI/LO register pair in the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (plus MADD/MSUB when enabled) from ID/EX. It runs a pipelined multiply or an iterative radix-2 divide, then drives the load enables and data inputs of the HI_Reg and LO_Reg instances. It raises a stall to hazard control while a result is pending and a MFHI/MFLO wants to read.

Parameters:
MUL_LAT, 2, cycles from accepted multiply to HI/LO write; legal range 1..4.
DIV_ITERS, 32, quotient bits per divide; fixed at 32 for MIPS, exposed only for shortened unit tests.

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  reset; one clock, asynchronous and active-high
Start  in  1  valid operation this cycle from ID/EX
Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
A  in  32  rs operand
B  in  32  rt operand
HI_cur  in  32  current HI_Reg output, used by MADD/MSUB
LO_cur  in  32  current LO_Reg output, used by MADD/MSUB
Abort  in  1  pipeline flush; cancels the in-flight operation
MfRead  in  1  MFHI/MFLO in ID this cycle
HI_Ld  out  1  load enable to HI_Reg
LO_Ld  out  1  load enable to LO_Reg
HI_in  out  32  data to HI_Reg
LO_in  out  32  data to LO_Reg
Busy  out  1  operation in flight
Stall  out  1  hold IF/ID
Done  out  1  one-cycle pulse, coincident with the HI_Ld/LO_Ld write

Behaviour:
- Reset: state IDLE; HI_Ld, LO_Ld, Busy, Done = 0; HI_in, LO_in = 0; datapath registers cleared. Asserting Rst mid-operation aborts the operation with no write.
- All outputs except Stall are registered. Stall = MfRead & (Busy | Start) and is combinational.
- States:
  - IDLE: accepts Start.
  - MUL: counts MUL_LAT-1 cycles.
  - DIV: DIV_ITERS iterations.
  - FIX: applies the sign correction.
  - WR: asserts HI_Ld/LO_Ld and Done for one cycle, then returns to IDLE. WR is also entered directly from IDLE for MTHI/MTLO.
- Start is honoured only in IDLE. Start while Busy is ignored, because hazard control guarantees it never happens. A bench check flags any violation.
- MTHI: next cycle HI_Ld=1, HI_in=A, LO_Ld=0, Busy stays 0. MTLO is the same, driving LO.
- MULT/MULTU: 64-bit signed or unsigned product of A and B. HI_in = product[63:32], LO_in = product[31:0]. Both enables pulse exactly MUL_LAT cycles after Start.
- DIV/DIVU: restoring division on magnitudes.
  - Latency is DIV_ITERS+2 cycles from Start to Done (34 at default).
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - B == 0: LO = 0xFFFFFFFF, HI = A. Same latency, no exception.
  - DIV with A = 0x80000000 and B = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Busy is high from the cycle after Start through the WR cycle. It is never high for MTHI/MTLO.
- Abort in any non-IDLE state: next edge goes to IDLE with no HI_Ld/LO_Ld and no Done. Abort in the same cycle as Start suppresses the Start.
- HI_cur/LO_cur are sampled on Start, so HI/LO writes made during execution do not corrupt the accumulate.

Optional Feature:
HILO_MADD_EN
- Defined: Op 110 computes {HI,LO} = {HI_cur,LO_cur} + signed(A*B), mod 2^64. Op 111 computes {HI_cur,LO_cur} - signed(A*B), mod 2^64. Latency is MUL_LAT+1.
- Undefined: Op 110/111 are ignored. The state stays IDLE, with no Busy, no write and no Done, and no adder is synthesised.

Decomposition:
- Shared package hilo_pkg holds:
  - the Op encodings as localparams OP_MULT..OP_MSUB;
  - the state encoding (IDLE, MUL, DIV, FIX, WR);
  - DIV0_LO = 32'hFFFFFFFF.
- One sub-module, hilo_div_core, owns the iterative restoring divider: the start/busy/done handshake, the magnitude iteration and the sign fix-up. The controller owns the FSM, the multiply pipeline and the write mux.

Test Plan:
- MULT, A=0xFFFFFFFE (-2), B=3 -> after 2 cycles HI_Ld=LO_Ld=1, HI_in=0xFFFFFFFF, LO_in=0xFFFFFFFA, Done pulse. MULTU with the same operands -> HI_in=0x00000002, LO_in=0xFFFFFFFA.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> Done at cycle 34, LO_in=0xFFFFFFFD, HI_in=0xFFFFFFFF. DIVU, A=100, B=7 -> LO=14, HI=2.
- DIVU, A=0x12345678, B=0 -> LO_in=0xFFFFFFFF, HI_in=0x12345678. DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO, A=0xCAFEF00D -> next cycle LO_Ld=1, LO_in=0xCAFEF00D, HI_Ld=0, Busy never high.
- DIV started, Abort at cycle 10 -> IDLE next cycle, no Ld/Done. Rst pulsed mid-DIV -> all outputs 0 immediately. MfRead during Busy -> Stall=1 until the WR cycle.
- With HILO_MADD_EN: HI_cur=0, LO_cur=0xFFFFFFFF, MADD with A=1, B=1 -> HI_in=1, LO_in=0 at cycle 3. Without the macro, the same stimulus produces no write.
